// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage and its branch history table.
package fetch_stage_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned CNT_W = 32;

    localparam logic [6:0]      OPCODE_BRANCH = 7'b1100011;
    localparam logic [ILEN-1:0] NOP_INSTR     = 32'h00000013;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t SNT = 2'd0;
    localparam bht_ctr_t WNT = 2'd1;
    localparam bht_ctr_t WT  = 2'd2;
    localparam bht_ctr_t ST  = 2'd3;

    // Saturating 2-bit counter step toward the resolved outcome.
    function automatic bht_ctr_t sat_update(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t res;
        res = ctr;
        if (taken) begin
            if (ctr != ST) res = ctr + 2'd1;
        end else begin
            if (ctr != SNT) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_history_table.sv
// Table of 2-bit saturating counters: one combinational read port, one update port.
module branch_history_table
    import fetch_stage_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 64,
    parameter bht_ctr_t    BHT_INIT    = WNT,
    localparam int unsigned IDX_W      = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    bht_ctr_t bht [BHT_ENTRIES];

    // Read returns the pre-update counter; a same-cycle update shows up next cycle.
    assign rd_taken = bht[rd_idx][1];

    // Counter array reset and single saturating update per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                bht[i] <= BHT_INIT;
            end
        end else if (upd_valid) begin
            bht[upd_idx] <= sat_update(bht[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, BHT-based direction prediction, branch perf counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter bht_ctr_t    BHT_INIT    = WNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic             upd_mispredict,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [ILEN-1:0]  imem_rdata,
    output logic [XLEN-1:0]  pc_out,
    output logic [ILEN-1:0]  instr_out,
    output logic             prediction_out,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_next;
    logic [XLEN-1:0]  seq_pc;
    logic [XLEN-1:0]  imm_b;
    logic             is_branch;
    logic             bht_taken;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             unused_bits;

    // Index bits below the word offset and above the table size are don't-care.
    assign unused_bits = ^{upd_pc[XLEN-1:IDX_W+2], upd_pc[1:0], redirect_pc[1:0]};

    assign imem_addr = pc;
    assign pc_out    = pc;
    assign instr_out = rst ? NOP_INSTR : imem_rdata;

    assign is_branch = (imem_rdata[6:0] == OPCODE_BRANCH);
    assign imm_b     = {{51{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                        imem_rdata[30:25], imem_rdata[11:8], 1'b0};

    assign rd_idx  = pc[IDX_W+1:2];
    assign upd_idx = upd_pc[IDX_W+1:2];

    assign prediction_out = ~rst & is_branch & bht_taken;

    branch_history_table #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .BHT_INIT    (BHT_INIT)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (rd_idx),
        .rd_taken  (bht_taken),
        .upd_valid (upd_valid),
        .upd_idx   (upd_idx),
        .upd_taken (upd_taken)
    );

    assign seq_pc = prediction_out ? (pc + imm_b) : (pc + 64'd4);

    // Next fetch address: redirect beats stall, stall beats prediction.
    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (!stall) begin
            pc_next = {seq_pc[XLEN-1:2], 2'b00};
        end
    end

    // PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // Resolved-branch and mispredict counters, free-running with wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (upd_valid) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (upd_mispredict) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios then randomized traffic.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int unsigned N_BHT     = 64;
    localparam int unsigned MEM_WORDS = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic        upd_taken;
    logic        upd_mispredict;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [63:0] pc_out;
    logic [31:0] instr_out;
    logic        prediction_out;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC    (64'h0),
        .BHT_ENTRIES (N_BHT),
        .BHT_INIT    (WNT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .pc_out         (pc_out),
        .instr_out      (instr_out),
        .prediction_out (prediction_out),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    // Instruction memory plus the intended meaning of each word.
    logic [31:0] mem     [MEM_WORDS];
    bit          mem_br  [MEM_WORDS];
    longint      mem_off [MEM_WORDS];

    assign imem_rdata = mem[imem_addr[9:2]];

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        pred;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state.
    logic [63:0] m_pc;
    int          mb [N_BHT];
    logic [31:0] m_bc;
    logic [31:0] m_mc;

    function automatic int word_of(input logic [63:0] a);
        return int'((a / 64'd4) % 64'(MEM_WORDS));
    endfunction

    function automatic int bidx(input logic [63:0] a);
        return int'((a / 64'd4) % 64'(N_BHT));
    endfunction

    function automatic logic [31:0] make_br(input longint off, input logic [2:0] f3);
        logic [12:0] im;
        im = 13'(off);
        return {im[12], im[10:5], 5'd2, 5'd1, f3, im[4:1], im[11], 7'b1100011};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 64'h0;
        for (int i = 0; i < int'(N_BHT); i++) mb[i] = 1;
        m_bc = 32'h0;
        m_mc = 32'h0;
    endtask

    task automatic set_mem(input int w, input longint off, input logic [2:0] f3);
        mem[w]     = make_br(off, f3);
        mem_br[w]  = 1'b1;
        mem_off[w] = off;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            mem[i] = NOP_INSTR; mem_br[i] = 1'b0; mem_off[i] = 0;
        end
    endtask

    task automatic fill_random();
        logic [31:0] tmp;
        longint      off;
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            if ($urandom_range(0, 1) == 1) begin
                off = (longint'($urandom_range(0, 32)) - 16) * 4;
                set_mem(i, off, 3'($urandom_range(0, 7)));
            end else begin
                tmp = $urandom();
                mem[i] = {tmp[31:7], 7'b0010011}; mem_br[i] = 1'b0; mem_off[i] = 0;
            end
        end
    endtask

    // One cycle: drive inputs at negedge, push expected outputs, advance the model.
    task automatic cyc(input logic r, input logic s, input logic rd, input logic [63:0] rpc,
                       input logic uv, input logic [63:0] upc, input logic ut, input logic um);
        exp_t e;
        int   w;
        int   b;
        logic pred;
        @(negedge clk);
        rst = r; stall = s; redirect = rd; redirect_pc = rpc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_mispredict = um;
        if (r) begin
            model_reset();
            e.pc = 64'h0; e.instr = NOP_INSTR; e.pred = 1'b0; e.bc = 32'h0; e.mc = 32'h0;
            q.push_back(e);
        end else begin
            w    = word_of(m_pc);
            pred = mem_br[w] && (mb[bidx(m_pc)] >= 2);
            e.pc = m_pc; e.instr = mem[w]; e.pred = pred; e.bc = m_bc; e.mc = m_mc;
            q.push_back(e);
            if (rd)         m_pc = rpc & ~64'h3;
            else if (!s)    m_pc = pred ? m_pc + 64'(mem_off[w]) : m_pc + 64'd4;
            if (uv) begin
                b = bidx(upc);
                if (ut) mb[b] = (mb[b] < 3) ? mb[b] + 1 : 3;
                else    mb[b] = (mb[b] > 0) ? mb[b] - 1 : 0;
                m_bc = m_bc + 32'd1;
                if (um) m_mc = m_mc + 32'd1;
            end
        end
    endtask

    task automatic idle(input logic s);
        cyc(1'b0, s, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
    endtask

    // Monitor: compare every presented output set against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("pc_out",         pc_out,               e.pc);
                chk("imem_addr",      imem_addr,            e.pc);
                chk("instr_out",      64'(instr_out),       64'(e.instr));
                chk("prediction_out", 64'(prediction_out),  64'(e.pred));
                chk("branch_cnt",     64'(branch_cnt),      64'(e.bc));
                chk("mispred_cnt",    64'(mispred_cnt),     64'(e.mc));
            end
        end
    end

    initial begin
        int          guard;
        logic        r, s, rd, uv;
        logic [63:0] rpc;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
        fill_nop();
        set_mem(4, 64'sh20, 3'b000);     // beq at 0x10, +0x20
        set_mem(64, -64'sd8, 3'b001);    // bne at 0x100, -8
        model_reset();

        // Reset, sequential fetch, then reset asserted mid-run at pc 0x40.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        guard = 0;
        while (m_pc != 64'h40 && guard < 32) begin
            idle(1'b0);
            guard++;
        end
        chk("reach_pc_40", m_pc, 64'h40);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);

        // Train idx 4 twice taken, fetch the beq at 0x10 -> 0x30.
        cyc(0, 0, 0, 0, 1, 64'h10, 1, 0);
        cyc(0, 0, 0, 0, 1, 64'h10, 1, 0);
        repeat (4) idle(1'b0);
        repeat (3) cyc(0, 1, 0, 0, 1, 64'h10, 0, 0);
        cyc(0, 0, 1, 64'h10, 0, 0, 0, 0);
        repeat (2) idle(1'b0);

        // Backward bne at 0x100: saturate taken, then drive down to not-taken.
        repeat (7) cyc(0, 1, 0, 0, 1, 64'h100, 1, 0);
        cyc(0, 0, 1, 64'h100, 0, 0, 0, 0);
        repeat (2) idle(1'b0);
        repeat (3) cyc(0, 1, 0, 0, 1, 64'h100, 0, 0);
        cyc(0, 0, 1, 64'h100, 0, 0, 0, 0);
        repeat (2) idle(1'b0);

        // Redirect wins over stall; then a 3-cycle stall.
        cyc(0, 1, 1, 64'h203, 0, 0, 0, 0);
        repeat (3) idle(1'b1);
        idle(1'b0);

        // Same-index read and update in one cycle.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 64'h10, 0, 0, 0, 0);
        cyc(0, 0, 1, 64'h10, 1, 64'h10, 1, 0);
        repeat (2) idle(1'b0);

        // Counters: 10 updates (3 mispredicts) and 2 stray mispredict pulses.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 1, 64'h800, 1'(i % 2), 1'(i < 3));
        repeat (2) cyc(0, 1, 0, 0, 0, 64'h800, 0, 1);
        idle(1'b1);
        chk("model_branch_cnt", 64'(m_bc), 64'd10);
        chk("model_mispred_cnt", 64'(m_mc), 64'd3);

        // Counter wrap from all-ones.
        @(posedge clk);
        #1;
        force dut.branch_cnt  = 32'hFFFFFFFF;
        force dut.mispred_cnt = 32'hFFFFFFFF;
        #1;
        release dut.branch_cnt;
        release dut.mispred_cnt;
        m_bc = 32'hFFFFFFFF;
        m_mc = 32'hFFFFFFFF;
        cyc(0, 1, 0, 0, 1, 64'h800, 1, 1);
        idle(1'b1);
        idle(1'b1);

        // Randomized traffic against a freshly randomized memory.
        @(posedge clk);
        #1;
        fill_random();
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 4) == 0);
            rd = ($urandom_range(0, 9) == 0);
            uv = ($urandom_range(0, 4) < 2);
            rpc = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFF3
                                               : 64'($urandom_range(0, 1023));
            cyc(r, s, rd, rpc, uv, 64'($urandom_range(0, 1023)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        #3;
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
